// File: rtl/fpu_multiplier16_pkg.sv
// Shared constants and state type for the FP16 significand multiplier.
// Provides `FP16_FRACW (fraction field width) when the build has not set it already.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

package fpu_multiplier16_pkg;

    localparam int unsigned FP16_FRACW = `FP16_FRACW;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/fpu_multiplier16.sv
// Sequential shift-and-add multiplier for FP16 fraction fields; one multiplier bit per clock.
// Optional MUL_EARLY_TERM_EN ends the BUSY phase once no multiplier bits remain.
module fpu_multiplier16
    import fpu_multiplier16_pkg::*;
#(
    parameter int unsigned WIDTH = `FP16_FRACW
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   mulIn1,
    input  logic [WIDTH-1:0]   mulIn2,
    input  logic               start,
    output logic [2*WIDTH-1:0] mulOut,
    output logic               done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mul_state_t         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               last;

    // The result is published one edge after the final accumulate step, so
    // mulOut only ever carries a complete product.
`ifdef MUL_EARLY_TERM_EN
    assign last = (mplier == '0);
`else
    assign last = (count == CW'(WIDTH));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            mulOut <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, mulIn1};
                        mplier <= mulIn2;
                        acc    <= '0;
                        count  <= '0;
                        done   <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (last) begin
                        mulOut <= acc;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_multiplier16.sv
// Self-checking bench for fpu_multiplier16: behavioural product/latency model plus literal cases.
// Honours MUL_EARLY_TERM_EN for the expected latency.
module tb_fpu_multiplier16;

    localparam int W = 10;

    logic             clock;
    logic             reset;
    logic [W-1:0]     mulIn1;
    logic [W-1:0]     mulIn2;
    logic             start;
    logic [2*W-1:0]   mulOut;
    logic             done;

    int errors = 0;
    int checks = 0;

    fpu_multiplier16 #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .mulIn1 (mulIn1),
        .mulIn2 (mulIn2),
        .start  (start),
        .mulOut (mulOut),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Edges from the capture edge to the edge that raises done.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int h = -1;
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return h + 2;
`else
        return W + 1;
`endif
    endfunction

    // Behavioural model: product by plain arithmetic, timing by latency formula.
    int             phase = 0;
    int             remain = 0;
    logic [2*W-1:0] prod = '0;
    logic [2*W-1:0] exp_out = '0;
    logic           exp_done = 1'b0;
    bit             mvalid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            phase = 0; exp_done = 1'b0; exp_out = '0; mvalid = 1'b1;
        end else begin
            case (phase)
                0: if (start) begin
                    prod = (2*W)'(mulIn1) * (2*W)'(mulIn2);
                    remain = exp_lat(mulIn2);
                    phase = 1;
                    exp_done = 1'b0;
                end
                1: begin
                    remain--;
                    if (remain == 0) begin
                        phase = 2; exp_done = 1'b1; exp_out = prod;
                    end
                end
                default: if (!start) begin
                    phase = 0; exp_done = 1'b0;
                end
            endcase
        end
        #1;
        if (mvalid) begin
            chk("cyc_done", 32'(done), 32'(exp_done));
            chk("cyc_mulOut", 32'(mulOut), 32'(exp_out));
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] lit, input int lit_lat, input string nm);
        int lat;
        @(negedge clock);
        mulIn1 = a; mulIn2 = b; start = 1'b1;
        @(posedge clock);
        lat = 0;
        forever begin
            @(posedge clock); #2;
            lat++;
            if (done) break;
            if (lat > 40) break;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(lit_lat));
        chk({nm, "_prod"}, 32'(mulOut), 32'(lit));
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #2;
        chk({nm, "_drop"}, 32'(done), 32'd0);
        chk({nm, "_keep"}, 32'(mulOut), 32'(lit));
    endtask

    initial begin
        int rises;
        logic prev;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; mulIn1 = '0; mulIn2 = '0;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mulOut", 32'(mulOut), 32'd0);
        @(negedge clock); reset = 1'b0;

`ifdef MUL_EARLY_TERM_EN
        do_op(10'd3, 10'd4, 20'd12, 4, "small");
        do_op(10'd517, 10'd0, 20'd0, 1, "mplier_zero");
`else
        do_op(10'd3, 10'd4, 20'd12, 11, "small");
        do_op(10'd517, 10'd0, 20'd0, 11, "mplier_zero");
`endif
        do_op(10'd1023, 10'd1023, 20'hFF801, 11, "max");
        do_op(10'd0, 10'd517, 20'd0, exp_lat(10'd517), "mcand_zero");

        // Held start: exactly one result, stable for the whole hold.
        @(negedge clock);
        mulIn1 = 10'd5; mulIn2 = 10'd7; start = 1'b1;
        rises = 0; prev = done;
        repeat (100) begin
            @(posedge clock); #2;
            if (done && !prev) rises++;
            prev = done;
        end
        chk("held_rises", 32'(rises), 32'd1);
        chk("held_done", 32'(done), 32'd1);
        chk("held_prod", 32'(mulOut), 32'd35);
        @(negedge clock); start = 1'b0;
        @(posedge clock); #2;
        chk("held_drop", 32'(done), 32'd0);
        do_op(10'd100, 10'd200, 20'd20000, exp_lat(10'd200), "retrigger");

        // Operands changed during BUSY are ignored.
        @(negedge clock);
        mulIn1 = 10'd21; mulIn2 = 10'd1000; start = 1'b1;
        @(negedge clock);
        mulIn1 = 10'd999; mulIn2 = 10'd3; start = 1'b0;
        rises = 0;
        while (!done && rises < 40) begin
            @(posedge clock); #2; rises++;
        end
        chk("opchange_done", 32'(done), 32'd1);
        chk("opchange_prod", 32'(mulOut), 32'd21000);
        @(posedge clock); #2;

        // Reset five edges into BUSY aborts with no done pulse.
        @(negedge clock);
        mulIn1 = 10'd77; mulIn2 = 10'd1023; start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #2;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mulOut", 32'(mulOut), 32'd0);
        @(negedge clock); reset = 1'b0;
        rises = 0;
        repeat (20) begin
            @(posedge clock); #2;
            if (done) rises++;
        end
        chk("abort_no_done", 32'(rises), 32'd0);

        // Randomized operands, with edge values mixed in.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: ra = '1;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = '1;
                2: rb = W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            do_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), exp_lat(rb), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
